// File: rtl/puck_engine.sv
// puck_engine: per-frame puck motion, paddle hits, wall reflection, goal scoring and game FSM.
// Latency: state and outputs update one clk after tick rises; goal pulses are one clk wide, aligned with the score.
// Backpressure: none, every tick rising edge is consumed. Optional friction is built when PUCK_FRICTION_EN is defined.
module puck_engine #(
  parameter int COORD_W        = 10,
  parameter int VEL_W          = 5,
  parameter int SCORE_W        = 3,
  parameter int WIN_SCORE      = 5,
  parameter int X_MIN          = 234,
  parameter int X_MAX          = 694,
  parameter int Y_MIN          = 111,
  parameter int Y_MAX          = 431,
  parameter int GOAL_Y_LO      = 246,
  parameter int GOAL_Y_HI      = 296,
  parameter int CENTER_X       = 464,
  parameter int CENTER_Y       = 271,
  parameter int SERVE_OFF      = 137,
  parameter int HIT_R2         = 700,
  parameter int VMAX           = 7,
  parameter int SERVE_VX       = 7,
  parameter int HOLD_TICKS     = 30,
  parameter int FRICTION_TICKS = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic               restart,
  input  logic [COORD_W-1:0] ball1_x,
  input  logic [COORD_W-1:0] ball1_y,
  input  logic [COORD_W-1:0] ball2_x,
  input  logic [COORD_W-1:0] ball2_y,
  output logic [COORD_W-1:0] puck_x,
  output logic [COORD_W-1:0] puck_y,
  output logic [VEL_W-1:0]   vel_x,
  output logic [VEL_W-1:0]   vel_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               goal1,
  output logic               goal2,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam int DW  = COORD_W + 1;   // signed coordinate difference
  localparam int SW  = COORD_W + 2;   // signed next position / velocity sum
  localparam int PW  = 2 * DW;        // signed square
  localparam int D2W = 2 * DW + 1;    // sum of squares
  localparam int HW  = $clog2(HOLD_TICKS);

  typedef enum logic [1:0] {PLAY = 2'd0, HOLD = 2'd1, RESPAWN = 2'd2, OVER = 2'd3} state_t;

  localparam logic [COORD_W-1:0]   X_MIN_C   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0]   X_MAX_C   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0]   Y_MIN_C   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0]   Y_MAX_C   = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0]   GY_LO_C   = COORD_W'(GOAL_Y_LO);
  localparam logic [COORD_W-1:0]   GY_HI_C   = COORD_W'(GOAL_Y_HI);
  localparam logic [COORD_W-1:0]   CX_C      = COORD_W'(CENTER_X);
  localparam logic [COORD_W-1:0]   CY_C      = COORD_W'(CENTER_Y);
  localparam logic [COORD_W-1:0]   RESP_L_C  = COORD_W'(CENTER_X - SERVE_OFF);
  localparam logic [COORD_W-1:0]   RESP_R_C  = COORD_W'(CENTER_X + SERVE_OFF);
  localparam logic signed [SW-1:0] X_MIN_S   = SW'(X_MIN);
  localparam logic signed [SW-1:0] X_MAX_S   = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MIN_S   = SW'(Y_MIN);
  localparam logic signed [SW-1:0] Y_MAX_S   = SW'(Y_MAX);
  localparam logic signed [SW-1:0] VMAX_S    = SW'(VMAX);
  localparam logic [VEL_W-1:0]     VMAX_P    = VEL_W'(VMAX);
  localparam logic [VEL_W-1:0]     VMAX_N    = VEL_W'(-VMAX);
  localparam logic [VEL_W-1:0]     SERVE_V   = VEL_W'(SERVE_VX);
  localparam logic [SCORE_W-1:0]   WIN_C     = SCORE_W'(WIN_SCORE);
  localparam logic [D2W-1:0]       HIT_R2_C  = D2W'(HIT_R2);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t               st_q, st_d;
  logic                 tick_q, step, left_q, left_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [COORD_W-1:0]   puck_x_d, puck_y_d;
  logic [VEL_W-1:0]     vel_x_d, vel_y_d, vx_h, vy_h, vx_f, vy_f;
  logic [SCORE_W-1:0]   score1_d, score2_d;
  logic                 goal1_d, goal2_d;
  logic signed [DW-1:0] dx1, dy1, dx2, dy2;
  logic [D2W-1:0]       d2_1, d2_2;
  logic signed [SW-1:0] nx, ny;
  logic                 in_win, goal_l, goal_r, hit1, hit2;

  function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [D2W-1:0] sq(input logic signed [DW-1:0] d);
    logic signed [PW-1:0] p;
    p = PW'(d) * PW'(d);
    return D2W'($unsigned(p));
  endfunction

  // Velocity after adding a paddle offset, clamped to +/-VMAX.
  function automatic logic [VEL_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > VMAX_S)       return VMAX_P;
    else if (v < -VMAX_S) return VMAX_N;
    else                  return v[VEL_W-1:0];
  endfunction

  assign step      = tick & ~tick_q;
  assign state     = st_q;
  assign game_over = (st_q == OVER);

  assign dx1  = diff(puck_x, ball1_x);
  assign dy1  = diff(puck_y, ball1_y);
  assign dx2  = diff(puck_x, ball2_x);
  assign dy2  = diff(puck_y, ball2_y);
  assign d2_1 = sq(dx1) + sq(dy1);
  assign d2_2 = sq(dx2) + sq(dy2);
  assign hit1 = (d2_1 <= HIT_R2_C);
  assign hit2 = (d2_2 <= HIT_R2_C);

  assign in_win = (puck_y >= GY_LO_C) && (puck_y <= GY_HI_C);
  assign goal_l = (puck_x <= X_MIN_C) && in_win;
  assign goal_r = (puck_x >= X_MAX_C) && in_win;

  // Paddle hit: paddle 1 wins when both are in range.
  always_comb begin
    vx_h = vel_x;
    vy_h = vel_y;
    if (hit1) begin
      vx_h = sat(SW'($signed(vel_x)) + SW'(dx1));
      vy_h = sat(SW'($signed(vel_y)) + SW'(dy1));
    end else if (hit2) begin
      vx_h = sat(SW'($signed(vel_x)) + SW'(dx2));
      vy_h = sat(SW'($signed(vel_y)) + SW'(dy2));
    end
  end

`ifdef PUCK_FRICTION_EN
  localparam int            FW        = $clog2(FRICTION_TICKS);
  localparam logic [FW-1:0] FRIC_LAST = FW'(FRICTION_TICKS - 1);
  logic [FW-1:0] fric_q, fric_d;
  logic          fric_hit;

  function automatic logic [VEL_W-1:0] toward0(input logic [VEL_W-1:0] v);
    if (v == '0)          return v;
    else if (v[VEL_W-1])  return v + 1'b1;
    else                  return v - 1'b1;
  endfunction

  assign fric_hit = (fric_q == FRIC_LAST);
  assign vx_f     = fric_hit ? toward0(vx_h) : vx_h;
  assign vy_f     = fric_hit ? toward0(vy_h) : vy_h;

  // Friction step counter, only advances on non-goal PLAY steps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) fric_q <= '0;
    else     fric_q <= fric_d;
  end
`else
  // FRICTION_TICKS has no effect without the friction feature.
  localparam int unused_fric_ticks = FRICTION_TICKS;
  assign vx_f = vx_h;
  assign vy_f = vy_h;
`endif

  assign nx = $signed({2'b00, puck_x}) + SW'($signed(vx_f));
  assign ny = $signed({2'b00, puck_y}) + SW'($signed(vy_f));

  // Next-state and datapath: restart beats step; nothing moves between steps.
  always_comb begin
    st_d     = st_q;
    puck_x_d = puck_x;
    puck_y_d = puck_y;
    vel_x_d  = vel_x;
    vel_y_d  = vel_y;
    score1_d = score1;
    score2_d = score2;
    goal1_d  = 1'b0;
    goal2_d  = 1'b0;
    hold_d   = hold_q;
    left_d   = left_q;
`ifdef PUCK_FRICTION_EN
    fric_d   = fric_q;
`endif
    if (restart) begin
      st_d     = PLAY;
      puck_x_d = CX_C;
      puck_y_d = CY_C;
      vel_x_d  = SERVE_V;
      vel_y_d  = '0;
      score1_d = '0;
      score2_d = '0;
      hold_d   = '0;
      left_d   = 1'b0;
`ifdef PUCK_FRICTION_EN
      fric_d   = '0;
`endif
    end else if (step) begin
      case (st_q)
        PLAY: begin
          if (goal_l || goal_r) begin
            vel_x_d = '0;
            vel_y_d = '0;
            st_d    = HOLD;
            left_d  = goal_l;
            if (goal_l) begin
              goal1_d = 1'b1;
              if (score1 != WIN_C) score1_d = score1 + 1'b1;
            end else begin
              goal2_d = 1'b1;
              if (score2 != WIN_C) score2_d = score2 + 1'b1;
            end
          end else begin
`ifdef PUCK_FRICTION_EN
            fric_d = fric_hit ? '0 : fric_q + 1'b1;
`endif
            vel_x_d  = vx_f;
            vel_y_d  = vy_f;
            puck_x_d = nx[COORD_W-1:0];
            puck_y_d = ny[COORD_W-1:0];
            if (nx < X_MIN_S)      begin puck_x_d = X_MIN_C; vel_x_d = -vx_f; end
            else if (nx > X_MAX_S) begin puck_x_d = X_MAX_C; vel_x_d = -vx_f; end
            if (ny < Y_MIN_S)      begin puck_y_d = Y_MIN_C; vel_y_d = -vy_f; end
            else if (ny > Y_MAX_S) begin puck_y_d = Y_MAX_C; vel_y_d = -vy_f; end
          end
        end
        HOLD: begin
          vel_x_d = '0;
          vel_y_d = '0;
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            // Puck is placed on leaving HOLD so the display shows it during RESPAWN/OVER.
            if (score1 == WIN_C || score2 == WIN_C) begin
              st_d     = OVER;
              puck_x_d = CX_C;
            end else begin
              st_d     = RESPAWN;
              puck_x_d = left_q ? RESP_L_C : RESP_R_C;
            end
            puck_y_d = CY_C;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RESPAWN: begin
          puck_x_d = left_q ? RESP_L_C : RESP_R_C;
          puck_y_d = CY_C;
          vel_x_d  = '0;
          vel_y_d  = '0;
          st_d     = PLAY;
`ifdef PUCK_FRICTION_EN
          fric_d   = '0;
`endif
        end
        OVER: begin
          puck_x_d = CX_C;
          puck_y_d = CY_C;
          vel_x_d  = '0;
          vel_y_d  = '0;
        end
        default: st_d = PLAY;
      endcase
    end
  end

  // State registers; clr restores the power-on picture immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q <= 1'b0;
      st_q   <= PLAY;
      puck_x <= CX_C;
      puck_y <= CY_C;
      vel_x  <= SERVE_V;
      vel_y  <= '0;
      score1 <= '0;
      score2 <= '0;
      goal1  <= 1'b0;
      goal2  <= 1'b0;
      hold_q <= '0;
      left_q <= 1'b0;
    end else begin
      tick_q <= tick;
      st_q   <= st_d;
      puck_x <= puck_x_d;
      puck_y <= puck_y_d;
      vel_x  <= vel_x_d;
      vel_y  <= vel_y_d;
      score1 <= score1_d;
      score2 <= score2_d;
      goal1  <= goal1_d;
      goal2  <= goal2_d;
      hold_q <= hold_d;
      left_q <= left_d;
    end
  end

endmodule

// File: tb/tb_puck_engine.sv
// tb_puck_engine: directed game scenarios plus random paddle play against an integer game model.
// Latency: outputs compared one clk after each tick rise, then again while tick stays high/low.
// Backpressure: n/a.
module tb_puck_engine;

  localparam int COORD_W = 10, VEL_W = 5, SCORE_W = 3, WIN_SCORE = 5;
  localparam int X_MIN = 234, X_MAX = 694, Y_MIN = 111, Y_MAX = 431;
  localparam int GOAL_Y_LO = 246, GOAL_Y_HI = 296, CENTER_X = 464, CENTER_Y = 271;
  localparam int SERVE_OFF = 137, HIT_R2 = 700, VMAX = 7, SERVE_VX = 7, HOLD_TICKS = 30;
`ifdef PUCK_FRICTION_EN
  localparam int FRICTION_TICKS = 16;
`endif

  logic clk = 1'b0, clr = 1'b1, tick = 1'b0, restart = 1'b0;
  logic [COORD_W-1:0] ball1_x, ball1_y, ball2_x, ball2_y, puck_x, puck_y;
  logic [VEL_W-1:0]   vel_x, vel_y;
  logic [SCORE_W-1:0] score1, score2;
  logic goal1, goal2, game_over;
  logic [1:0] state;

  puck_engine dut (
    .clk(clk), .clr(clr), .tick(tick), .restart(restart),
    .ball1_x(ball1_x), .ball1_y(ball1_y), .ball2_x(ball2_x), .ball2_y(ball2_y),
    .puck_x(puck_x), .puck_y(puck_y), .vel_x(vel_x), .vel_y(vel_y),
    .score1(score1), .score2(score2), .goal1(goal1), .goal2(goal2),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Game model: state 0 play, 1 hold, 2 respawn, 3 over.
  int m_px, m_py, m_vx, m_vy, m_s1, m_s2, m_st, m_hold, m_g1, m_g2, m_left, m_fric;
  int b1x = 0, b1y = 0, b2x = 1023, b2y = 1023;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".puck_x"}, puck_x, m_px);
    check({tag, ".puck_y"}, puck_y, m_py);
    check({tag, ".vel_x"}, $signed(vel_x), m_vx);
    check({tag, ".vel_y"}, $signed(vel_y), m_vy);
    check({tag, ".score1"}, score1, m_s1);
    check({tag, ".score2"}, score2, m_s2);
    check({tag, ".goal1"}, goal1, m_g1);
    check({tag, ".goal2"}, goal2, m_g2);
    check({tag, ".game_over"}, game_over, (m_st == 3) ? 1 : 0);
    check({tag, ".state"}, state, m_st);
  endtask

  function automatic int clampv(input int v);
    return (v > VMAX) ? VMAX : (v < -VMAX) ? -VMAX : v;
  endfunction

  function automatic int toward_zero(input int v);
    return (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
  endfunction

  task automatic model_reset();
    m_px = CENTER_X; m_py = CENTER_Y; m_vx = SERVE_VX; m_vy = 0;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_hold = 0; m_g1 = 0; m_g2 = 0; m_left = 0; m_fric = 0;
  endtask

  task automatic model_step();
    int dx, dy, nx, ny;
    bit in_win;
    m_g1 = 0; m_g2 = 0;
    case (m_st)
      0: begin
        in_win = (m_py >= GOAL_Y_LO) && (m_py <= GOAL_Y_HI);
        if (m_px <= X_MIN && in_win) begin
          if (m_s1 < WIN_SCORE) m_s1++;
          m_g1 = 1; m_vx = 0; m_vy = 0; m_st = 1; m_left = 1;
        end else if (m_px >= X_MAX && in_win) begin
          if (m_s2 < WIN_SCORE) m_s2++;
          m_g2 = 1; m_vx = 0; m_vy = 0; m_st = 1; m_left = 0;
        end else begin
          dx = m_px - b1x; dy = m_py - b1y;
          if (dx * dx + dy * dy > HIT_R2) begin
            dx = m_px - b2x; dy = m_py - b2y;
          end
          if (dx * dx + dy * dy <= HIT_R2) begin
            m_vx = clampv(m_vx + dx); m_vy = clampv(m_vy + dy);
          end
`ifdef PUCK_FRICTION_EN
          m_fric++;
          if (m_fric == FRICTION_TICKS) begin
            m_fric = 0; m_vx = toward_zero(m_vx); m_vy = toward_zero(m_vy);
          end
`endif
          nx = m_px + m_vx; ny = m_py + m_vy;
          if (nx < X_MIN) begin nx = X_MIN; m_vx = -m_vx; end
          else if (nx > X_MAX) begin nx = X_MAX; m_vx = -m_vx; end
          if (ny < Y_MIN) begin ny = Y_MIN; m_vy = -m_vy; end
          else if (ny > Y_MAX) begin ny = Y_MAX; m_vy = -m_vy; end
          m_px = nx; m_py = ny;
        end
      end
      1: begin
        m_hold++;
        if (m_hold == HOLD_TICKS) begin
          m_hold = 0;
          m_py = CENTER_Y;
          if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin m_st = 3; m_px = CENTER_X; end
          else begin m_st = 2; m_px = m_left ? CENTER_X - SERVE_OFF : CENTER_X + SERVE_OFF; end
        end
      end
      2: begin
        m_px = m_left ? CENTER_X - SERVE_OFF : CENTER_X + SERVE_OFF;
        m_py = CENTER_Y; m_vx = 0; m_vy = 0; m_st = 0; m_fric = 0;
      end
      default: begin m_px = CENTER_X; m_py = CENTER_Y; end
    endcase
  endtask

  task automatic set_paddles(input int a, input int b, input int c, input int d);
    b1x = a; b1y = b; b2x = c; b2y = d;
    ball1_x = b1x[COORD_W-1:0]; ball1_y = b1y[COORD_W-1:0];
    ball2_x = b2x[COORD_W-1:0]; ball2_y = b2y[COORD_W-1:0];
  endtask

  // One tick edge (optionally with restart), tick held high for hl cycles.
  task automatic do_tick(input bit rs, input int hl);
    @(negedge clk);
    tick = 1'b1; restart = rs;
    @(negedge clk);
    restart = 1'b0;
    if (rs) model_reset(); else model_step();
    compare_all("step");
    for (int i = 1; i < hl; i++) begin
      @(negedge clk);
      m_g1 = 0; m_g2 = 0;
      compare_all("tick_high");
    end
    tick = 1'b0;
    @(negedge clk);
    m_g1 = 0; m_g2 = 0;
    compare_all("tick_low");
  endtask

  task automatic run_to_hold(input int budget);
    int n = 0;
    while (m_st != 1 && n < budget) begin do_tick(1'b0, 1); n++; end
    check("hold_reached", state, 1);
  endtask

  // From HOLD: wait out the hold, respawn, kick the puck in direction dir, play until the next goal.
  task automatic serve_and_score(input int dir);
    repeat (HOLD_TICKS) do_tick(1'b0, 1);
    do_tick(1'b0, 1);
    set_paddles(m_px - 10 * dir, m_py, 1023, 1023);
    do_tick(1'b0, 1);
    set_paddles(0, 0, 1023, 1023);
    run_to_hold(150);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    set_paddles(0, 0, 1023, 1023);
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    clr = 1'b0;

    // Free run to the right wall, then a right goal.
    repeat (10) do_tick(1'b0, 1);
    check("free10_px", puck_x, 534);
    repeat (23) do_tick(1'b0, 1);
    check("wall_px", puck_x, 694);
    check("wall_vx", $signed(vel_x), -7);
    do_tick(1'b0, 1);
    check("rgoal_score2", score2, 1);
    check("rgoal_state", state, 1);
    repeat (HOLD_TICKS) do_tick(1'b0, 1);
    check("respawn_state", state, 2);
    check("respawn_px", puck_x, 601);
    do_tick(1'b0, 1);
    check("play_state", state, 0);

    // Both paddles in range: paddle 1 decides.
    set_paddles(591, 271, 601, 281);
    do_tick(1'b0, 1);
    check("hit_vx", $signed(vel_x), 7);
    check("hit_vy", $signed(vel_y), 0);
    check("hit_px", puck_x, 608);
    set_paddles(0, 0, 1023, 1023);
    run_to_hold(100);
    repeat (3) serve_and_score(1);
    check("win_score2", score2, 5);
    repeat (HOLD_TICKS) do_tick(1'b0, 1);
    check("over_flag", game_over, 1);
    check("over_px", puck_x, 464);
    repeat (5) do_tick(1'b0, 2);
    check("over_stays", state, 3);

    // New game, left goal and left respawn point.
    do_tick(1'b1, 1);
    run_to_hold(100);
    serve_and_score(-1);
    check("lgoal_score1", score1, 1);
    repeat (HOLD_TICKS) do_tick(1'b0, 1);
    check("lrespawn_px", puck_x, 327);
    check("lrespawn_py", puck_y, 271);
    do_tick(1'b0, 1);
    set_paddles(317, 271, 1023, 1023);
    do_tick(1'b0, 1);
    set_paddles(0, 0, 1023, 1023);
    run_to_hold(150);
    repeat (2) do_tick(1'b0, 1);
    do_tick(1'b1, 1);
    check("restart_score2", score2, 0);
    check("restart_state", state, 0);
    check("restart_vx", $signed(vel_x), 7);

    // Asynchronous clear in the middle of HOLD.
    run_to_hold(100);
    repeat (3) do_tick(1'b0, 1);
    @(negedge clk);
    #2 clr = 1'b1;
    #1 model_reset();
    compare_all("clr_async");
    @(negedge clk);
    clr = 1'b0;

    // Random paddle play.
    for (int k = 0; k < 400; k++) begin
      int r, a, b, c, d;
      r = $urandom_range(0, 9);
      a = 0; b = 0; c = 1023; d = 1023;
      if (r inside {4, 5, 6, 9}) begin
        a = m_px + int'($urandom_range(0, 80)) - 40;
        b = m_py + int'($urandom_range(0, 80)) - 40;
      end
      if (r >= 7) begin
        c = m_px + int'($urandom_range(0, 80)) - 40;
        d = m_py + int'($urandom_range(0, 80)) - 40;
      end
      set_paddles(a, b, c, d);
      do_tick($urandom_range(0, 39) == 0, int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/puck_engine.md
Name: puck_engine

Overview:
- Parametrised next-generation puck physics and scoring engine for the air-hockey display pipeline.
- Once per frame tick it advances the puck with signed per-axis velocity and resolves mallet hits from two paddles. It also resolves wall reflections and goals.
- Sequences goal hold, respawn and game-over through an explicit FSM.
- Sits between the paddle trackers and the VGA renderer/score display.

Parameters:
COORD_W, 10, width of all pixel coordinates (unsigned)
VEL_W, 5, width of signed velocity per axis
SCORE_W, 3, width of each score counter
WIN_SCORE, 5, score that ends the game
X_MIN, 234, left play-field bound
X_MAX, 694, right play-field bound
Y_MIN, 111, top play-field bound
Y_MAX, 431, bottom play-field bound
GOAL_Y_LO, 246, goal mouth top (inclusive)
GOAL_Y_HI, 296, goal mouth bottom (inclusive)
CENTER_X, 464, centre x
CENTER_Y, 271, centre y
SERVE_OFF, 137, x offset of respawn point from centre
HIT_R2, 700, squared hit radius
VMAX, 7, velocity magnitude clamp
SERVE_VX, 7, x velocity after reset/restart
HOLD_TICKS, 30, ticks frozen after a goal
FRICTION_TICKS, 16, ticks per friction decrement (optional feature only)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
tick  in  1  frame strobe level; rising edge detected internally
restart  in  1  synchronous one-cycle new-game request
ball1_x, ball1_y  in  COORD_W each  paddle 1 centre
ball2_x, ball2_y  in  COORD_W each  paddle 2 centre
puck_x, puck_y  out  COORD_W each  puck centre
vel_x, vel_y  out  VEL_W each  signed puck velocity
score1, score2  out  SCORE_W each  player scores
goal1, goal2  out  1  one-cycle pulse on left/right goal
game_over  out  1  high in GAME_OVER
state  out  2  PLAY=0, HOLD=1, RESPAWN=2, OVER=3

Behaviour:
- Reset values (clr=1):
  - puck=(CENTER_X,CENTER_Y), vel=(SERVE_VX,0).
  - scores=0, goal pulses=0, game_over=0, state=PLAY, hold counter=0, tick history=0.
- Step: step = tick & ~tick_q, where tick_q is the registered tick. All state updates occur only on step cycles; outputs change the cycle after tick rises.
- restart: has priority over step. Performs the reset-value load synchronously in any state.
- PLAY, evaluated on current puck position in this order:
  1. Goal check. If puck_x<=X_MIN and GOAL_Y_LO<=puck_y<=GOAL_Y_HI, it is a left goal: score1++, goal1 pulse, vel=0, ->HOLD. Right goal uses puck_x>=X_MAX and the same y window: score2++, goal2 pulse. No motion or collision on a goal step.
  2. Hit check.
     - Differences are signed, COORD_W+1 bits. d2 = dx²+dy², computed at full width, no truncation.
     - Paddle 1 has priority over paddle 2. On d2<=HIT_R2: vel += (puck-ball) per axis, saturated to ±VMAX.
  3. Motion with reflection.
     - next = puck + vel (signed).
     - If next_x<X_MIN or next_x>X_MAX: puck_x is clamped to the bound and vel_x negated. Same rule for y.
     - Clamping takes precedence over goal-mouth entry; the goal is detected on the following step.
- HOLD:
  - puck frozen, vel=0.
  - Hold counter increments per step. At HOLD_TICKS-1 it clears, then the FSM goes to OVER if either score==WIN_SCORE, else to RESPAWN.
- RESPAWN, one step:
  - puck=(CENTER_X-SERVE_OFF, CENTER_Y) after a left goal, (CENTER_X+SERVE_OFF, CENTER_Y) after a right goal.
  - vel=0, ->PLAY.
- OVER:
  - puck=(CENTER_X,CENTER_Y), vel=0, game_over=1.
  - Scores held for display. Exit only via restart or clr.
- Scores never wrap: increments are suppressed at WIN_SCORE.
- Goal pulses are exactly one clk wide, registered, and aligned with the score update.
- clr mid-operation: every register returns to reset values immediately, independent of clk.

Optional Feature:
PUCK_FRICTION_EN.
- Defined: in PLAY, a step counter counts steps. Every FRICTION_TICKS steps, each nonzero velocity component moves 1 toward 0. This is applied after the hit update and before motion, and the counter clears on restart/respawn.
- Undefined: velocity changes only on hits, reflections, goals, restart and reset; no counter is instantiated.

Test Plan:
- Free run: reset, 10 ticks, paddles far away -> puck_x advances 7 per tick; after crossing X_MAX=694, puck_x=694 and vel_x=-7.
- Hit: puck (400,271) vel (0,0), ball1 at (390,271), one tick -> vel_x=+7 (10 saturated), vel_y=0, puck_x=407. Same with ball2 also in range -> ball1 result only.
- Left goal: puck forced to (234,260) in PLAY, tick -> goal1 one-cycle pulse, score1=1, state=HOLD. After 30 ticks -> RESPAWN, puck=(327,271). Next tick -> PLAY.
- Game over: score2=4, right goal at (694,280) -> score2=5. After hold -> state=OVER, game_over=1, puck=(464,271). Further ticks do not change it.
- restart and tick in the same cycle during HOLD -> scores=0, state=PLAY, vel=(7,0). clr asserted mid-HOLD -> immediate reset values.
- PUCK_FRICTION_EN defined, vel=(5,-3), no hits -> after 16 ticks vel=(4,-2); after 48 ticks vel=(2,0).
